// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: resolves a Width-bit sample MSB first
// by driving trial codes to an external DAC and reading back a synchronized comparator.
module sar_adc_ctrl #(
  parameter int Width        = 8,
  parameter int SettleCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             comp_i,
  output logic [Width-1:0] dac_o,
  output logic [Width-1:0] data_o,
  output logic             eosar_o,
  output logic             busy_o
);

  localparam int IdxW = $clog2(Width);
  localparam logic [7:0]      SettleLast = 8'(SettleCycles - 1);
  localparam logic [IdxW-1:0] IdxTop     = IdxW'(Width - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  trial_q, trial_d;
  logic [Width-1:0]  data_q, data_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              eosar_q, eosar_d;
  logic [1:0]        comp_sync_q, comp_sync_d;
  logic              comp_s;

  // comp_i is asynchronous to clk_i; only the second flop may feed decisions.
  assign comp_sync_d = {comp_sync_q[0], comp_i};
  assign comp_s      = comp_sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    trial_d   = trial_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    eosar_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          trial_d            = '0;
          trial_d[Width-1]   = 1'b1;
          bit_idx_d          = IdxTop;
          cnt_d              = '0;
          state_d            = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DECIDE: begin
        if (!comp_s) trial_d[bit_idx_q] = 1'b0;
        if (bit_idx_q != '0) begin
          trial_d[bit_idx_q - 1'b1] = 1'b1;
          bit_idx_d                 = bit_idx_q - 1'b1;
          state_d                   = ST_SETTLE;
        end else begin
          data_d  = trial_d;
          eosar_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      trial_q     <= '0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      eosar_q     <= 1'b0;
      comp_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      trial_q     <= trial_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      eosar_q     <= eosar_d;
      comp_sync_q <= comp_sync_d;
    end
  end

  assign dac_o   = trial_q;
  assign data_o  = data_q;
  assign eosar_o = eosar_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: default 8-bit instance plus a 10-bit,
// two-cycle-settle instance, each driven by an ideal comparator model.
module tb_sar_adc_ctrl;

  typedef struct {
    logic [15:0] data;
    int          start;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic [7:0] dac_exp_q[$];

  // Instance A: defaults
  logic       rst_a = 1'b1, start_a = 1'b0, comp_a;
  logic [7:0] dac_a, data_a, vin_a = 8'h00;
  logic       eosar_a, busy_a;
  logic       glitch_en = 1'b0, glitch_a;
  int         sa = 0;

  // Instance B: Width 10, SettleCycles 2
  logic       rst_b = 1'b1, start_b = 1'b0, comp_b;
  logic [9:0] dac_b, data_b, vin_b = 10'h000;
  logic       eosar_b, busy_b;

  sar_adc_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .comp_i(comp_a),
    .dac_o(dac_a), .data_o(data_a), .eosar_o(eosar_a), .busy_o(busy_a)
  );

  sar_adc_ctrl #(.Width(10), .SettleCycles(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .comp_i(comp_b),
    .dac_o(dac_b), .data_o(data_b), .eosar_o(eosar_b), .busy_o(busy_b)
  );

  // Wrong comparator value in the first two SETTLE cycles of every bit; the
  // value sampled for DECIDE comes from the third SETTLE cycle.
  assign glitch_a = glitch_en && (cyc - sa >= 1) && (cyc - sa <= 40) &&
                    (((cyc - sa - 1) % 5) < 2);
  assign comp_a   = (vin_a >= dac_a) ^ glitch_a;
  assign comp_b   = (vin_b >= dac_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT signals end of conversion.
  logic       eos_prev_a = 1'b0, eos_prev_b = 1'b0;
  logic [7:0] dac_prev_a = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (eos_prev_a) begin
      check("a_eosar_single_cycle", eosar_a, 0);
      check("a_busy_after_done", busy_a, 0);
    end
    if (eosar_a === 1'b1) begin
      check("a_eosar_expected", (q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_data", data_a, e.data);
        check("a_latency", cyc - e.start, e.lat);
      end
    end
    if (dac_a !== dac_prev_a && dac_exp_q.size() > 0)
      check("a_dac_seq", dac_a, dac_exp_q.pop_front());
    dac_prev_a = dac_a;
    eos_prev_a = eosar_a;

    if (eos_prev_b) begin
      check("b_eosar_single_cycle", eosar_b, 0);
      check("b_busy_after_done", busy_b, 0);
    end
    if (eosar_b === 1'b1) begin
      check("b_eosar_expected", (q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_data", data_b, e.data);
        check("b_latency", cyc - e.start, e.lat);
      end
    end
    eos_prev_b = eosar_b;
  end

  task automatic start_a_conv(input logic [7:0] vin, input bit expect_done);
    vin_a = vin;
    sa    = cyc;
    if (expect_done) q_a.push_back('{data: 16'(vin), start: cyc, lat: 41});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_b_conv(input logic [9:0] vin);
    vin_b = vin;
    q_b.push_back('{data: 16'(vin), start: cyc, lat: 31});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic pulse_a_at(input int s, input int n);
    while (cyc - s < n) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, q_a.size() + q_b.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("a_reset_dac", dac_a, 0);
    check("a_reset_data", data_a, 0);
    check("a_reset_eosar", eosar_a, 0);
    check("a_reset_busy", busy_a, 0);

    // Mid-scale code with the expected trial-code walk
    dac_exp_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    start_a_conv(8'hA5, 1'b1);
    drain("drain_a5");
    check("a_dac_seq_consumed", dac_exp_q.size(), 0);

    // Endpoints
    start_a_conv(8'h00, 1'b1);
    drain("drain_00");
    start_a_conv(8'hFF, 1'b1);
    drain("drain_ff");

    // Start pulses while busy (including DONE) are ignored; cycle 42 restarts
    start_a_conv(8'h5A, 1'b1);
    s = sa;
    pulse_a_at(s, 5);
    pulse_a_at(s, 20);
    pulse_a_at(s, 41);
    while (cyc - s < 42) @(negedge clk);
    start_a_conv(8'h33, 1'b1);
    drain("drain_busy_starts");

    // Reset mid-conversion, with a simultaneous start that must lose to reset
    start_a_conv(8'h77, 1'b0);
    s = sa;
    while (cyc - s < 17) @(negedge clk);
    rst_a   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst_a   = 1'b0;
    start_a = 1'b0;
    check("a_abort_dac", dac_a, 0);
    check("a_abort_busy", busy_a, 0);
    check("a_abort_data", data_a, 0);
    check("a_abort_eosar", eosar_a, 0);
    repeat (60) @(negedge clk);
    check("a_abort_stays_idle", busy_a, 0);
    start_a_conv(8'h3C, 1'b1);
    drain("drain_after_reset");

    // Comparator glitches confined to early SETTLE cycles
    glitch_en = 1'b1;
    start_a_conv(8'h96, 1'b1);
    drain("drain_glitch");
    glitch_en = 1'b0;

    // Wide, fast-settle instance
    start_b_conv(10'h2AA);
    drain("drain_b_2aa");
    start_b_conv(10'h155);
    drain("drain_b_155");
    start_b_conv(10'h3FF);
    drain("drain_b_3ff");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation ADC controller, directly downstream of the acquisition control FSM.
- Accepts a one-cycle `start_i` pulse, which the FSM drives from its `start_sar_o`.
- Drives the DAC trial code to the external DAC and reads back the analog comparator.
- Resolves a `Width`-bit sample one bit per step, MSB first.
- Returns `eosar_o`, which the FSM consumes as `eosar_i`, with the result on `data_o`, which feeds the UART transmitter.

## Interface

**Parameters**
- `Width`, default 8: ADC resolution in bits, range 2..16.
- `SettleCycles`, default 4: DAC/comparator settling wait per bit, in clock cycles, range 2..255.

**Ports**
- `clk_i` input 1: system clock. Single clock domain.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: start-conversion pulse. Accepted only in IDLE.
- `comp_i` input 1: asynchronous comparator output. 1 means Vin >= Vdac(`dac_o`).
- `dac_o` output `Width`: current trial code to the DAC. Registered.
- `data_o` output `Width`: last completed conversion result. Registered, held until the next completion.
- `eosar_o` output 1: end of conversion. One-cycle pulse, registered.
- `busy_o` output 1: high from the first SETTLE cycle through the DONE cycle.

## Operation

**Comparator synchronizer**
- `comp_i` passes through a 2-flop synchronizer. The second flop is `comp_s`.
- Only `comp_s` is used by the state machine.

**Internal registers**
- `trial` (`Width` bits). `dac_o` is driven from `trial`.
- `bit_idx`, `ceil(log2(Width))` bits.
- `cnt`, 8 bits.

**States**
- IDLE
  - `busy_o` = 0.
  - `start_i` = 1 → load `trial` = 1 << (`Width`-1), `bit_idx` = `Width`-1, `cnt` = 0 → SETTLE.
  - Otherwise stay. `dac_o` holds its last value.
- SETTLE
  - `cnt` increments each cycle.
  - When `cnt` = `SettleCycles`-1 → DECIDE, with `cnt` cleared.
  - SETTLE therefore lasts exactly `SettleCycles` cycles.
- DECIDE (one cycle)
  - If `comp_s` = 0, clear `trial[bit_idx]`. If `comp_s` = 1, keep it.
  - If `bit_idx` > 0:
    - Also set `trial[bit_idx-1]`.
    - Decrement `bit_idx`.
    - → SETTLE.
  - If `bit_idx` = 0:
    - `data_o` <= final `trial` (with bit 0 resolved).
    - `eosar_o` <= 1.
    - → DONE.
- DONE (one cycle)
  - `eosar_o` = 1 and `busy_o` = 1.
  - `eosar_o` <= 0 → IDLE.
- No other state is reachable. Illegal encodings → IDLE.

**Arithmetic**
- Bits are only set or cleared. No adds.
- The final code equals the largest code c with comparator(c) = 1, with ties resolved upward per the bit rule.
- All-zero and all-one results are legal.

**Boundary conditions**
- `start_i` in SETTLE, DECIDE or DONE is ignored. No queueing, no restart.
- `start_i` in the cycle after DONE (IDLE) is accepted normally.
- `rst_i` mid-conversion:
  - Next edge: IDLE; `dac_o`, `data_o`, `cnt`, `bit_idx`, synchronizer flops = 0; `eosar_o` = 0; `busy_o` = 0.
  - No `eosar_o` is emitted for the aborted conversion.
- `rst_i` has priority over `start_i` in the same cycle.
- `comp_i` toggling during SETTLE is don't-care. Only the `comp_s` value in the DECIDE cycle matters.
- `SettleCycles` ≥ 2 guarantees that `comp_s` in DECIDE reflects the current `dac_o`, because the synchronizer has 2-cycle latency.

## Timing

- Reset values: `dac_o` = 0, `data_o` = 0, `eosar_o` = 0, `busy_o` = 0, state IDLE.
- Take `start_i` sampled high at edge 0:
  - SETTLE begins at cycle 1. `dac_o` = MSB-only from cycle 1.
  - Each bit takes `SettleCycles` + 1 cycles.
  - DONE occurs at cycle `Width`·(`SettleCycles`+1)+1. `eosar_o` and the new `data_o` are visible in that cycle.
- Latency from `start_i` to `eosar_o` is `Width`·(`SettleCycles`+1)+1 cycles: 41 for the defaults.
- `dac_o` changes only on the cycle after a DECIDE.
- `data_o` changes only coincident with `eosar_o` rising.
- Minimum start-to-start period is latency + 1 cycles.

## Test plan

- **Ideal comparator, mid-scale code.**
  - Stimulus: model `comp_i` = (0xA5 >= `dac_o`), defaults, `start_i` pulse.
  - Required `dac_o` sequence: 80, C0, A0, B0, A8, A4, A6, A5.
  - Required result: `eosar_o` high exactly 41 cycles after start, `data_o` = 0xA5, `busy_o` low at cycle 42.
- **Endpoints.**
  - Vin = 0x00 → `data_o` = 0x00.
  - Vin = 0xFF → `data_o` = 0xFF.
  - Both with 41-cycle latency and a single-cycle `eosar_o`.
- **Start while busy.**
  - Stimulus: extra `start_i` pulses at cycles 5, 20 and 41 (DONE).
  - Required response: no effect; one `eosar_o` at cycle 41; a start at cycle 42 begins a new conversion with `eosar_o` at cycle 83.
- **Reset mid-conversion.**
  - Stimulus: `rst_i` at cycle 17.
  - Required at the next cycle: `dac_o` = 0, `busy_o` = 0, `data_o` = 0.
  - Required afterwards: no `eosar_o`; a subsequent start converts 0x3C correctly.
- **Settle/synchronizer.**
  - Stimulus: `SettleCycles` = 2, `Width` = 10, Vin = 0x2AA.
  - Required: `data_o` = 0x2AA, latency 31 cycles.
  - Stimulus: glitch `comp_i` to the wrong value during SETTLE only.
  - Required: the result is unchanged.
